// File: rtl/ball_motion_ctrl_if.sv
// ball_motion_ctrl_if: frame timing, collision flags and game flags into the
// ball controller, and the ball state back out to collision and draw logic.
// master = the surrounding game logic, slave = ball_motion_ctrl.
interface ball_motion_ctrl_if;
  logic              vsync;
  logic              start;
  logic              h_collision;
  logic              v_collision;
  logic              win;
  logic              lose;
  logic [9:0]        paddle_x;
  logic [9:0]        ball_x;
  logic [9:0]        ball_y;
  logic signed [3:0] ball_dx;
  logic signed [3:0] ball_dy;
  logic              frame_upd;
  logic              serving;

  modport master (
    output vsync, start, h_collision, v_collision, win, lose, paddle_x,
    input  ball_x, ball_y, ball_dx, ball_dy, frame_upd, serving
  );

  modport slave (
    input  vsync, start, h_collision, v_collision, win, lose, paddle_x,
    output ball_x, ball_y, ball_dx, ball_dy, frame_upd, serving
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: owns the breakout ball position and velocity.
// Collision flags are edge-detected during active video and latched as
// pending; all motion is committed once per frame at the vsync rising edge.
// Optional feature macro: BALL_PADDLE_ANGLE_EN (paddle offset sets |dx|).
module ball_motion_ctrl #(
  parameter int START_X      = 320,
  parameter int START_Y      = 400,
  parameter int BALL_R       = 5,
  parameter int LEFT_EDGE    = 0,
  parameter int RIGHT_EDGE   = 639,
  parameter int TOP_EDGE     = 0,
  parameter int BOTTOM_EDGE  = 479,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input logic               pxl_clk,
  input logic               reset,
  ball_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  // Wall tests and clamps share these limits: centre +/- radius vs. edge.
  localparam logic signed [10:0] X_LO = 11'(LEFT_EDGE + BALL_R);
  localparam logic signed [10:0] X_HI = 11'(RIGHT_EDGE - BALL_R);
  localparam logic signed [10:0] Y_LO = 11'(TOP_EDGE + BALL_R);
  localparam logic signed [10:0] Y_HI = 11'(BOTTOM_EDGE - BALL_R);

  localparam logic [9:0]        START_X_C = 10'(START_X);
  localparam logic [9:0]        START_Y_C = 10'(START_Y);
  localparam logic signed [3:0] SPEED_C   = 4'(SPEED);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);

  state_t            state_q, state_d;
  logic [9:0]        ball_x_q, ball_x_d;
  logic [9:0]        ball_y_q, ball_y_d;
  logic signed [3:0] ball_dx_q, ball_dx_d;
  logic signed [3:0] ball_dy_q, ball_dy_d;
  logic              frame_upd_q, frame_upd_d;
  logic              serving_q, serving_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              vsync_q, vsync_d;
  logic              hcol_q, hcol_d;
  logic              vcol_q, vcol_d;
  logic              h_pend_q, h_pend_d;
  logic              v_pend_q, v_pend_d;

  logic              tick_s;
  logic              h_edge_s;
  logic              v_edge_s;
  logic signed [3:0] dx_flip_s, dy_flip_s, dx_sel_s;
  logic signed [3:0] dx_abs_s, dy_abs_s;
  logic signed [3:0] dx_new_s, dy_new_s;
  logic signed [10:0] x_s, y_s, nx_s, ny_s;

`ifdef BALL_PADDLE_ANGLE_EN
  logic signed [10:0] off_s, off_abs_s;
  logic signed [3:0]  mag_s;
`else
  logic unused_paddle_s;
  assign unused_paddle_s = ^bus.paddle_x;
`endif

  assign tick_s   = bus.vsync & ~vsync_q;
  assign h_edge_s = bus.h_collision & ~hcol_q;
  assign v_edge_s = bus.v_collision & ~vcol_q;

  // Collision reflection, wall reflection and raw next position for a RUN frame.
  always_comb begin
    x_s       = $signed({1'b0, ball_x_q});
    y_s       = $signed({1'b0, ball_y_q});
    dx_flip_s = h_pend_q ? -ball_dx_q : ball_dx_q;
    dy_flip_s = v_pend_q ? -ball_dy_q : ball_dy_q;
    dx_sel_s  = dx_flip_s;
`ifdef BALL_PADDLE_ANGLE_EN
    off_s     = x_s - $signed({1'b0, bus.paddle_x});
    off_abs_s = off_s[10] ? -off_s : off_s;
    if (off_abs_s < 11'sd8) begin
      mag_s = 4'sd1;
    end else if (off_abs_s < 11'sd24) begin
      mag_s = 4'sd2;
    end else begin
      mag_s = 4'sd3;
    end
    // Paddle hit near the bottom: offset from paddle centre steers the ball.
    if (v_pend_q && (ball_y_q >= 10'(BOTTOM_EDGE - 32))) begin
      if (off_s > 11'sd0) begin
        dx_sel_s = mag_s;
      end else if (off_s < 11'sd0) begin
        dx_sel_s = -mag_s;
      end else begin
        dx_sel_s = dx_flip_s[3] ? -mag_s : mag_s;
      end
    end else begin
      dx_sel_s = dx_flip_s;
    end
`endif
    dx_abs_s = dx_sel_s[3] ? -dx_sel_s : dx_sel_s;
    dy_abs_s = dy_flip_s[3] ? -dy_flip_s : dy_flip_s;

    // Walls win over collisions: sign always ends up pointing inward.
    if ((x_s <= X_LO) && (dx_sel_s < 4'sd0)) begin
      dx_new_s = dx_abs_s;
    end else if ((x_s >= X_HI) && (dx_sel_s > 4'sd0)) begin
      dx_new_s = -dx_abs_s;
    end else begin
      dx_new_s = dx_sel_s;
    end
    if ((y_s <= Y_LO) && (dy_flip_s < 4'sd0)) begin
      dy_new_s = dy_abs_s;
    end else begin
      dy_new_s = dy_flip_s;
    end

    nx_s = x_s + $signed({{7{dx_new_s[3]}}, dx_new_s});
    ny_s = y_s + $signed({{7{dy_new_s[3]}}, dy_new_s});
  end

  // Next-state logic: edge capture, pending flags, FSM and frame commit.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    ball_dx_d   = ball_dx_q;
    ball_dy_d   = ball_dy_q;
    frame_cnt_d = frame_cnt_q;
    frame_upd_d = tick_s;
    vsync_d     = bus.vsync;
    hcol_d      = bus.h_collision;
    vcol_d      = bus.v_collision;

    // Pending flags collect hits during active video and drain on each tick.
    if (tick_s) begin
      h_pend_d = 1'b0;
      v_pend_d = 1'b0;
    end else begin
      h_pend_d = h_pend_q | (h_edge_s & ~bus.vsync);
      v_pend_d = v_pend_q | (v_edge_s & ~bus.vsync);
    end

    if (bus.start) begin
      state_d     = ST_SERVE;
      ball_x_d    = START_X_C;
      ball_y_d    = START_Y_C;
      ball_dx_d   = SPEED_C;
      ball_dy_d   = -SPEED_C;
      frame_cnt_d = '0;
      h_pend_d    = 1'b0;
      v_pend_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SERVE: begin
          if (tick_s) begin
            if (frame_cnt_q == CNT_LAST) begin
              state_d = ST_RUN;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_SERVE;
          end
        end
        ST_RUN: begin
          if (bus.win || bus.lose) begin
            state_d = ST_HALT;
          end else if (tick_s) begin
            ball_dx_d = dx_new_s;
            ball_dy_d = dy_new_s;
            if (nx_s < X_LO) begin
              ball_x_d = X_LO[9:0];
            end else if (nx_s > X_HI) begin
              ball_x_d = X_HI[9:0];
            end else begin
              ball_x_d = nx_s[9:0];
            end
            if (ny_s < Y_LO) begin
              ball_y_d = Y_LO[9:0];
            end else if (ny_s > Y_HI) begin
              ball_y_d = Y_HI[9:0];
            end else begin
              ball_y_d = ny_s[9:0];
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    serving_d = (state_d == ST_IDLE) || (state_d == ST_SERVE);
  end

  // State and output registers; reset parks the ball at the serve point in IDLE.
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= START_X_C;
      ball_y_q    <= START_Y_C;
      ball_dx_q   <= 4'sd0;
      ball_dy_q   <= 4'sd0;
      frame_upd_q <= 1'b0;
      serving_q   <= 1'b1;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      hcol_q      <= 1'b0;
      vcol_q      <= 1'b0;
      h_pend_q    <= 1'b0;
      v_pend_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      ball_dx_q   <= ball_dx_d;
      ball_dy_q   <= ball_dy_d;
      frame_upd_q <= frame_upd_d;
      serving_q   <= serving_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      hcol_q      <= hcol_d;
      vcol_q      <= vcol_d;
      h_pend_q    <= h_pend_d;
      v_pend_q    <= v_pend_d;
    end
  end

  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.ball_dx   = ball_dx_q;
  assign bus.ball_dy   = ball_dy_q;
  assign bus.frame_upd = frame_upd_q;
  assign bus.serving   = serving_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: table of frame-level steps with hand-computed ball
// state, plus hand-written sequences for tick-cycle edges and mid-run reset.
module tb_ball_motion_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  ball_motion_ctrl_if bus ();

  ball_motion_ctrl dut (
    .pxl_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic start;
    logic win;
    logic lose;
    logic hc;
    logic vc;
    int   act;
    int   nfr;
    int   ex;
    int   ey;
    int   edx;
    int   edy;
    logic eserv;
  } row_t;

  localparam int NROWS = 17;
  row_t rows [NROWS];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey,
                            input int edx, input int edy, input int eserv);
    check({tag, " x"}, int'(bus.ball_x), ex);
    check({tag, " y"}, int'(bus.ball_y), ey);
    check({tag, " dx"}, int'($signed(bus.ball_dx)), edx);
    check({tag, " dy"}, int'($signed(bus.ball_dy)), edy);
    check({tag, " serving"}, int'(bus.serving), eserv);
  endtask

  // One frame: active video (collision held over its middle), then 4 blanking cycles.
  task automatic frame(input logic hc, input logic vc, input int act,
                       output logic upd1, output logic upd2);
    bus.vsync = 1'b0;
    for (int i = 0; i < act; i++) begin
      bus.h_collision = hc && (i >= 1) && (i <= act - 2);
      bus.v_collision = vc && (i >= 1) && (i <= act - 2);
      @(negedge clk);
    end
    bus.h_collision = 1'b0;
    bus.v_collision = 1'b0;
    bus.vsync       = 1'b1;
    @(negedge clk);
    upd1 = bus.frame_upd;
    @(negedge clk);
    upd2 = bus.frame_upd;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic u1, u2;
    n_tests = 0;
    n_fail  = 0;

    //           start win   lose  hc    vc    act nfr  x    y    dx  dy  serving
    rows[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8,  59, 320, 400,  2, -2, 1'b1};
    rows[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,   1, 320, 400,  2, -2, 1'b0};
    rows[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,   1, 322, 398,  2, -2, 1'b0};
    rows[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 500, 1, 324, 400,  2,  2, 1'b0};
    rows[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,   1, 326, 402,  2,  2, 1'b0};
    rows[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,  36, 398, 474,  2,  2, 1'b0};
    rows[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,   1, 400, 474,  2,  2, 1'b0};
    rows[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 117, 634, 474,  2,  2, 1'b0};
    rows[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,   1, 632, 474, -2,  2, 1'b0};
    rows[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,   1, 630, 474, -2,  2, 1'b0};
    rows[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8,   1, 320, 400,  2, -2, 1'b1};
    rows[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,  59, 320, 400,  2, -2, 1'b0};
    rows[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 157, 634,  86,  2, -2, 1'b0};
    rows[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,   1, 632,  84, -2, -2, 1'b0};
    rows[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,  40, 552,   5, -2, -2, 1'b0};
    rows[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8,   1, 550,   7, -2,  2, 1'b0};
    rows[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8,   3, 550,   7, -2,  2, 1'b0};

    reset           = 1'b1;
    bus.vsync       = 1'b0;
    bus.start       = 1'b0;
    bus.h_collision = 1'b0;
    bus.v_collision = 1'b0;
    bus.win         = 1'b0;
    bus.lose        = 1'b0;
    bus.paddle_x    = 10'd320;
    repeat (2) @(negedge clk);
    check_ball("reset", 320, 400, 0, 0, 1);
    check("reset frame_upd", int'(bus.frame_upd), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < NROWS; r++) begin
      if (rows[r].start || rows[r].win || rows[r].lose) begin
        bus.start = rows[r].start;
        bus.win   = rows[r].win;
        bus.lose  = rows[r].lose;
        @(negedge clk);
        bus.start = 1'b0;
        bus.win   = 1'b0;
        bus.lose  = 1'b0;
      end
      u1 = 1'b0;
      u2 = 1'b0;
      for (int f = 0; f < rows[r].nfr; f++) begin
        frame(rows[r].hc, rows[r].vc, rows[r].act, u1, u2);
      end
      check_ball($sformatf("row%0d", r), rows[r].ex, rows[r].ey,
                 rows[r].edx, rows[r].edy, int'(rows[r].eserv));
      check($sformatf("row%0d frame_upd pulse", r), int'({u1, u2}), 2);
    end

    // Re-serve from HALT and run into the first moving frame.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int f = 0; f < 61; f++) frame(1'b0, 1'b0, 8, u1, u2);
    check_ball("reserve", 322, 398, 2, -2, 0);

    // Horizontal hit rising in the tick cycle itself must be ignored.
    bus.vsync = 1'b0;
    repeat (8) @(negedge clk);
    bus.vsync       = 1'b1;
    bus.h_collision = 1'b1;
    repeat (4) @(negedge clk);
    check_ball("tick-edge frame", 324, 396, 2, -2, 0);
    frame(1'b0, 1'b0, 8, u1, u2);
    check_ball("tick-edge dropped", 326, 394, 2, -2, 0);

    // Reset mid-frame with a hit pending: nothing of that frame survives.
    bus.vsync = 1'b0;
    repeat (2) @(negedge clk);
    bus.h_collision = 1'b1;
    bus.v_collision = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_ball("midrun reset", 320, 400, 0, 0, 1);
    check("midrun reset frame_upd", int'(bus.frame_upd), 0);
    reset           = 1'b0;
    bus.h_collision = 1'b0;
    bus.v_collision = 1'b0;
    @(negedge clk);
    frame(1'b0, 1'b0, 8, u1, u2);
    check_ball("idle after reset", 320, 400, 0, 0, 1);
    check("idle frame_upd pulse", int'({u1, u2}), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
